// File: rtl/inst_sequencer.sv
// Program-memory instruction sequencer: issues stored words over valid/ready in run, step or loop mode.
// Latency: start -> FETCH -> ISSUE, one word per 2 cycles plus GAP_CYCLES; stalls in ISSUE while inst_rdy_i is low.
module inst_sequencer #(
    parameter int INST_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 0,
    parameter int WRAP_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [INST_W-1:0] wr_data_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [1:0]        mode_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              abort_i,
    output logic [INST_W-1:0] inst_wd_o,
    output logic              inst_vld_o,
    input  logic              inst_rdy_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [WRAP_W-1:0] wraps_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_WAIT_STEP, S_DONE
    } state_t;

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0]   GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_W:0] LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic [INST_W-1:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              done_q, done_d;
    logic              vld_q, vld_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              step_mode_q, step_mode_d;
    logic              loop_mode_q, loop_mode_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [INST_W-1:0] wd_q;

    logic   busy;
    logic   last;
    state_t after_issue;

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign last = (({1'b0, pc_q} + (ADDR_W+1)'(1)) == len_q);

    always_comb begin
        if (GAP_CYCLES > 0) begin
            after_issue = S_GAP;
        end else if (step_mode_q) begin
            after_issue = S_WAIT_STEP;
        end else begin
            after_issue = S_FETCH;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wraps_d     = wraps_q;
        done_d      = done_q;
        vld_d       = vld_q;
        len_d       = len_q;
        step_mode_d = step_mode_q;
        loop_mode_d = loop_mode_q;
        gap_d       = gap_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i && !abort_i) begin
                    len_d       = (len_i > LEN_MAX) ? LEN_MAX : len_i;
                    step_mode_d = (mode_i == 2'b01);
                    loop_mode_d = (mode_i == 2'b10);
                    if (len_i == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        done_d  = 1'b0;
                        wraps_d = '0;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_ISSUE;
                vld_d   = 1'b1;
            end
            S_ISSUE: begin
                if (vld_q && inst_rdy_i) begin
                    vld_d   = 1'b0;
                    gap_d   = GAP_LOAD;
                    state_d = after_issue;
                    if (last && loop_mode_q) begin
                        pc_d = '0;
                        if (wraps_q != '1) begin
                            wraps_d = wraps_q + WRAP_W'(1);
                        end
                    end else if (last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = step_mode_q ? S_WAIT_STEP : S_FETCH;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            S_WAIT_STEP: begin
                if (step_i) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort still lets a coincident handshake advance pc/wraps above
        if (abort_i) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            wraps_q     <= '0;
            done_q      <= 1'b0;
            vld_q       <= 1'b0;
            len_q       <= '0;
            step_mode_q <= 1'b0;
            loop_mode_q <= 1'b0;
            gap_q       <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wraps_q     <= wraps_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            len_q       <= len_d;
            step_mode_q <= step_mode_d;
            loop_mode_q <= loop_mode_d;
            gap_q       <= gap_d;
            if (state_q == S_FETCH) begin
                wd_q <= mem[pc_q];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !busy && !rst_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign inst_wd_o  = wd_q;
    assign inst_vld_o = vld_q;
    assign pc_o       = pc_q;
    assign busy_o     = busy;
    assign done_o     = done_q;
    assign wraps_o    = wraps_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer: a GAP_CYCLES=0 instance for most scenarios and a GAP_CYCLES=3 instance.
module tb_inst_sequencer;
    localparam int IW = 8;
    localparam int AW = 8;
    localparam int WW = 8;
    localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, LOOP = 2'b10;
    localparam logic [IW-1:0] W0 = 8'b00000100, W1 = 8'b00010011, W2 = 8'b10000110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr_en, start, step, abort, rdy;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic [AW:0]   len;
    logic [1:0]    mode;
    logic [IW-1:0] wd;
    logic          vld, busy, done;
    logic [AW-1:0] pc;
    logic [WW-1:0] wraps;

    logic          g_wr_en, g_start, g_step, g_abort, g_rdy;
    logic [AW-1:0] g_wr_addr;
    logic [IW-1:0] g_wr_data;
    logic [AW:0]   g_len;
    logic [1:0]    g_mode;
    logic [IW-1:0] g_wd;
    logic          g_vld, g_busy, g_done;
    logic [AW-1:0] g_pc;
    logic [WW-1:0] g_wraps;

    inst_sequencer #(.INST_W(IW), .ADDR_W(AW), .GAP_CYCLES(0), .WRAP_W(WW)) u_dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .len_i(len), .mode_i(mode), .start_i(start), .step_i(step), .abort_i(abort),
        .inst_wd_o(wd), .inst_vld_o(vld), .inst_rdy_i(rdy), .pc_o(pc), .busy_o(busy),
        .done_o(done), .wraps_o(wraps)
    );

    inst_sequencer #(.INST_W(IW), .ADDR_W(AW), .GAP_CYCLES(3), .WRAP_W(WW)) u_gap (
        .clk_i(clk), .rst_i(rst), .wr_en_i(g_wr_en), .wr_addr_i(g_wr_addr), .wr_data_i(g_wr_data),
        .len_i(g_len), .mode_i(g_mode), .start_i(g_start), .step_i(g_step), .abort_i(g_abort),
        .inst_wd_o(g_wd), .inst_vld_o(g_vld), .inst_rdy_i(g_rdy), .pc_o(g_pc), .busy_o(g_busy),
        .done_o(g_done), .wraps_o(g_wraps)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] gexp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (!rst && vld && rdy) begin
            hs_cnt++;
            if (exp_q.size() == 0) flag_fail("unexpected transfer", wd);
            else chk("transfer word", wd, exp_q.pop_front());
        end
        if (!rst && g_vld && g_rdy) begin
            if (gexp_q.size() == 0) flag_fail("gap unexpected transfer", g_wd);
            else chk("gap transfer word", g_wd, gexp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [AW:0] l, input logic [1:0] m);
        len = l; mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_prog();
        exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
    endtask

    task automatic count_to_done(output int c);
        c = 0;
        while (!done && c < 200) begin
            tick();
            c++;
        end
        if (!done) flag_fail("done timeout", c);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " inst_wd"}, wd, 0);
        chk({tag, " inst_vld"}, vld, 0);
        chk({tag, " pc"}, pc, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " wraps"}, wraps, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, base, guard;
        logic ok;
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; step = 1'b0; abort = 1'b0; rdy = 1'b0;
        wr_addr = '0; wr_data = '0; len = '0; mode = RUN;
        g_wr_en = 1'b0; g_start = 1'b0; g_step = 1'b0; g_abort = 1'b0; g_rdy = 1'b0;
        g_wr_addr = '0; g_wr_data = '0; g_len = '0; g_mode = RUN;
        tick(); tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        wr(0, W0); wr(1, W1); wr(2, W2);

        // Run mode, always ready: transfers at start+2, +4, +6.
        rdy = 1'b1;
        push_prog();
        go(3, RUN);
        count_to_done(cyc);
        chk("run cycles to done", cyc, 6);
        chk("run done", done, 1);
        chk("run pc", pc, 2);
        chk("run busy", busy, 0);

        // Second word stalled for 5 cycles.
        push_prog();
        go(3, RUN);
        tick(); tick();
        rdy = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!(vld === 1'b1 && wd === W1)) ok = 1'b0;
        end
        chk("stall holds word", ok, 1);
        rdy = 1'b1;
        count_to_done(cyc);
        chk("stall cycles to done", cyc + 8, 11);
        chk("stall pc", pc, 2);

        // Step mode with an extra step pulse during ISSUE.
        exp_q.push_back(W0); exp_q.push_back(W1);
        rdy = 1'b0;
        go(2, STEP);
        tick();
        chk("step first valid", vld, 1);
        step = 1'b1; tick(); step = 1'b0;
        rdy = 1'b1;
        tick();
        repeat (3) tick();
        chk("step waits vld", vld, 0);
        chk("step waits busy", busy, 1);
        chk("step waits done", done, 0);
        step = 1'b1; tick(); step = 1'b0;
        repeat (4) tick();
        step = 1'b1; tick(); step = 1'b0;
        count_to_done(cyc);
        chk("step done", done, 1);
        chk("step pc", pc, 1);

        // Abort coinciding with a handshake: transfer counts, pc advances, IDLE.
        exp_q.push_back(W0);
        go(3, RUN);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort+hs pc", pc, 1);
        chk("abort+hs busy", busy, 0);
        chk("abort+hs done", done, 0);
        chk("abort+hs vld", vld, 0);

        // Loop mode: 10 transfers then abort.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(W0); exp_q.push_back(W1);
        end
        base = hs_cnt;
        go(2, LOOP);
        guard = 0;
        while (hs_cnt - base < 10 && guard < 100) begin
            tick();
            guard++;
        end
        if (hs_cnt - base < 10) flag_fail("loop transfer timeout", hs_cnt - base);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("loop wraps", wraps, 5);
        chk("loop pc", pc, 0);
        chk("loop busy", busy, 0);
        chk("loop vld", vld, 0);
        chk("loop done", done, 0);

        // len=0 completes immediately.
        go(0, RUN);
        chk("len0 done", done, 1);
        chk("len0 busy", busy, 0);
        chk("len0 vld", vld, 0);

        // Write while busy is ignored; rerun with mode 11 behaves as run.
        push_prog();
        rdy = 1'b0;
        go(3, RUN);
        tick();
        wr(0, 8'hFF);
        rdy = 1'b1;
        count_to_done(cyc);
        push_prog();
        go(3, 2'b11);
        count_to_done(cyc);
        chk("mode11 cycles to done", cyc, 6);
        chk("mode11 pc", pc, 2);

        // Reset mid-ISSUE.
        rdy = 1'b0;
        go(3, RUN);
        tick();
        chk("pre-reset vld", vld, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_outputs("mid-issue reset");

        // GAP_CYCLES=3 instance: 3 idle cycles between handshake and next FETCH.
        g_wr_en = 1'b1; g_wr_addr = 0; g_wr_data = W0; tick();
        g_wr_addr = 1; g_wr_data = W1; tick();
        g_wr_en = 1'b0;
        gexp_q.push_back(W0); gexp_q.push_back(W1);
        g_rdy = 1'b1; g_len = 2; g_mode = RUN; g_start = 1'b1;
        tick();
        g_start = 1'b0;
        cyc = 0;
        ok = 1'b1;
        while (!g_done && cyc < 100) begin
            tick();
            cyc++;
            if (cyc >= 2 && cyc <= 5 && (g_vld || !g_busy)) ok = 1'b0;
        end
        chk("gap idle window", ok, 1);
        chk("gap cycles to done", cyc, 7);
        chk("gap done", g_done, 1);
        chk("gap pc", g_pc, 1);

        tick(); tick();
        chk("scoreboard drained", exp_q.size(), 0);
        chk("gap scoreboard drained", gexp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
